// File: rtl/ifres_pkg.sv
// rtl/ifres_pkg.sv - shared state enum, default sizes and sum-width helper for ifres_accum
package ifres_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // A full window of maximum samples fits exactly, so the running sum never wraps.
  function automatic int sum_width(input int width, input int depth);
    return width + $clog2(depth);
  endfunction

endpackage

// File: rtl/ifres_minmax.sv
// rtl/ifres_minmax.sv - combinational max/min reduction tree over DEPTH samples
module ifres_minmax #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic [WIDTH-1:0] data [DEPTH],
  output logic [WIDTH-1:0] data_max,
  output logic [WIDTH-1:0] data_min
);

  // Heap layout: leaves at DEPTH..2*DEPTH-1, node i reduces children 2i and 2i+1.
  logic [WIDTH-1:0] mx [2*DEPTH];
  logic [WIDTH-1:0] mn [2*DEPTH];

  always_comb begin
    mx[0] = '0;
    mn[0] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mx[DEPTH+i] = data[i];
      mn[DEPTH+i] = data[i];
    end
    for (int i = DEPTH - 1; i >= 1; i--) begin
      mx[i] = (mx[2*i] > mx[2*i+1]) ? mx[2*i] : mx[2*i+1];
      mn[i] = (mn[2*i] < mn[2*i+1]) ? mn[2*i] : mn[2*i+1];
    end
  end

  assign data_max = mx[1];
  assign data_min = mn[1];

endmodule

// File: rtl/ifres_accum.sv
// rtl/ifres_accum.sv - sliding-window sum/max/min accumulator with valid/ready handshakes
module ifres_accum
  import ifres_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [WIDTH-1:0]                    in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                flush,
  output logic [sum_width(WIDTH, DEPTH)-1:0]  out_sum,
  output logic [WIDTH-1:0]                    out_max,
  output logic [WIDTH-1:0]                    out_min,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [$clog2(DEPTH):0]              count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = sum_width(WIDTH, DEPTH);

  logic [WIDTH-1:0] win      [DEPTH];
  logic [WIDTH-1:0] win_next [DEPTH];
  logic [PW-1:0]    wptr;
  logic [SW-1:0]    sum;
  logic [SW-1:0]    sum_next;
  logic [WIDTH-1:0] evicted;
  logic [WIDTH-1:0] win_max;
  logic [WIDTH-1:0] win_min;
  state_t           state;
  logic             accept;
  logic             produce;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign produce  = accept && (state != FILL || count == CW'(DEPTH - 1));

  // Once full, the write pointer always sits on the oldest entry.
  assign evicted  = (state == FILL) ? '0 : win[wptr];
  assign sum_next = sum + SW'(in_data) - SW'(evicted);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      win_next[i] = (accept && wptr == PW'(i)) ? in_data : win[i];
    end
  end

  ifres_minmax #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_minmax (
    .data    (win_next),
    .data_max(win_max),
    .data_min(win_min)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
      wptr      <= '0;
      sum       <= '0;
      count     <= '0;
      out_sum   <= '0;
      out_max   <= '0;
      out_min   <= '0;
      out_valid <= 1'b0;
      state     <= FILL;
    end else if (flush) begin
      wptr      <= '0;
      sum       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      state     <= FILL;
    end else begin
      if (accept) begin
        win[wptr] <= in_data;
        wptr      <= wptr + 1'b1;
        sum       <= sum_next;
        if (state == FILL) count <= count + 1'b1;
      end
      if (produce) begin
        out_sum   <= sum_next;
        out_max   <= win_max;
        out_min   <= win_min;
        out_valid <= 1'b1;
        state     <= HOLD;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        state     <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_ifres_accum.sv
// tb/tb_ifres_accum.sv - randomized and directed checks of ifres_accum against a queue-based window model
module tb_ifres_accum;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [WIDTH-1:0]    in_data;
  logic                in_valid;
  logic                in_ready;
  logic                flush;
  logic [WIDTH+1:0]    out_sum;
  logic [WIDTH-1:0]    out_max;
  logic [WIDTH-1:0]    out_min;
  logic                out_valid;
  logic                out_ready;
  logic [2:0]          count;

  int checks = 0;
  int errors = 0;

  // Behavioural model: window as a FIFO queue, outputs recomputed from scratch.
  int q[$];
  int m_valid, m_sum, m_max, m_min;

  ifres_accum #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .flush    (flush),
    .out_sum  (out_sum),
    .out_max  (out_max),
    .out_min  (out_min),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear(input bit clear_outs);
    q.delete();
    m_valid = 0;
    if (clear_outs) begin
      m_sum = 0; m_max = 0; m_min = 0;
    end
  endtask

  task automatic compare_outputs();
    chk("out_valid", int'(out_valid), m_valid);
    chk("count", int'(count), q.size());
    if (m_valid != 0) begin
      chk("out_sum", int'(out_sum), m_sum);
      chk("out_max", int'(out_max), m_max);
      chk("out_min", int'(out_min), m_min);
    end
  endtask

  // Called at a negedge: drive, check ready, clock, update model, compare.
  task automatic step(input bit v, input int d, input bit r, input bit f);
    bit exp_rdy;
    in_valid = v; in_data = WIDTH'(d); out_ready = r; flush = f;
    exp_rdy = !f && (m_valid == 0 || r);
    #1;
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    @(posedge clk);
    if (f) begin
      model_clear(0);
    end else if (v && exp_rdy) begin
      q.push_back(d);
      if (q.size() > DEPTH) void'(q.pop_front());
      if (q.size() == DEPTH) begin
        m_valid = 1;
        m_sum = 0; m_max = 0; m_min = 255;
        foreach (q[i]) begin
          m_sum += q[i];
          if (q[i] > m_max) m_max = q[i];
          if (q[i] < m_min) m_min = q[i];
        end
      end
    end else if (r) begin
      m_valid = 0;
    end
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sum", int'(out_sum), 0);
    chk("rst_max", int'(out_max), 0);
    chk("rst_min", int'(out_min), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_ready", int'(in_ready), 1);
    model_clear(1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    pulse_reset();

    // Ramp window, then slide in 255, then saturate with 255s.
    step(1, 10, 1, 0); step(1, 20, 1, 0); step(1, 30, 1, 0); step(1, 40, 1, 0);
    chk("lit_sum_100", int'(out_sum), 100);
    chk("lit_max_40", int'(out_max), 40);
    chk("lit_min_10", int'(out_min), 10);
    step(1, 255, 1, 0);
    chk("lit_sum_345", int'(out_sum), 345);
    chk("lit_max_255", int'(out_max), 255);
    chk("lit_min_20", int'(out_min), 20);
    for (int i = 0; i < 3; i++) step(1, 255, 1, 0);
    chk("lit_sum_1020", int'(out_sum), 1020);
    chk("lit_eq_min", int'(out_min), 255);

    // Backpressure holds everything, release accepts in the same cycle.
    for (int i = 0; i < 5; i++) begin
      step(1, 7, 0, 0);
      chk("lit_hold_sum", int'(out_sum), 1020);
    end
    step(1, 7, 1, 0);
    chk("lit_release_sum", int'(out_sum), 772);
    chk("lit_release_min", int'(out_min), 7);

    // Flush drops the concurrent sample and empties the window.
    pulse_reset();
    step(1, 50, 1, 0); step(1, 60, 1, 0);
    step(1, 99, 1, 1);
    chk("lit_flush_count", int'(count), 0);
    step(1, 1, 1, 0); step(1, 2, 1, 0); step(1, 3, 1, 0); step(1, 4, 1, 0);
    chk("lit_sum_10", int'(out_sum), 10);

    // Reset mid-run with an output pending, then refill.
    step(1, 9, 0, 0);
    chk("lit_pending", int'(out_valid), 1);
    pulse_reset();
    for (int i = 0; i < 4; i++) step(1, 5, 1, 0);
    chk("lit_sum_20", int'(out_sum), 20);
    chk("lit_eq_5", int'(out_max), int'(out_min));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int d;
      d = ((i / 200) % 3 == 2) ? 128 : int'($urandom_range(0, 255));
      step(($urandom % 4) != 0, d, ($urandom % 3) != 0, ($urandom % 50) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
